// File: rtl/zbt_sram_ctrl_if.sv
// Local-bus side of the ZBT SRAM controller.
// The arbiter side uses the master modport and the controller uses the slave modport.
interface zbt_sram_ctrl_if #(
   parameter int ASIZE  = 18,
   parameter int DSIZE  = 32,
   parameter int BWSIZE = 4
);
   logic              req_valid;
   logic              req_ready;
   logic              req_rw_n;
   logic [ASIZE-1:0]  req_addr;
   logic [1:0]        req_len;
   logic [BWSIZE-1:0] req_bw;
   logic              wd_pop;
   logic [DSIZE-1:0]  wr_data;
   logic              rd_valid;
   logic [DSIZE-1:0]  rd_data;

   modport master (
      output req_valid, req_rw_n, req_addr, req_len, req_bw, wr_data,
      input  req_ready, wd_pop, rd_valid, rd_data
   );

   modport slave (
      input  req_valid, req_rw_n, req_addr, req_len, req_bw, wr_data,
      output req_ready, wd_pop, rd_valid, rd_data
   );
endinterface

// File: rtl/zbt_sram_ctrl.sv
// Pipelined ZBT (NoBL) SRAM controller: burst command engine, registered
// address/control pins, write data two cycles behind the address and read
// capture RD_LAT cycles behind it (RD_LAT in 1..4).
// Optional feature macro: ZBT_TURNAROUND_EN inserts one NOP cycle whenever a
// new command reverses the bus direction of the previously issued beat.
module zbt_sram_ctrl #(
   parameter int ASIZE  = 18,
   parameter int DSIZE  = 32,
   parameter int BWSIZE = 4,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   zbt_sram_ctrl_if.slave    bus,
   output logic [ASIZE-1:0]  ram_addr,
   output logic              ram_ce_n,
   output logic              ram_rw_n,
   output logic              ram_adv_ld_n,
   output logic [BWSIZE-1:0] ram_bw_n,
   output logic              ram_oe_n,
   output logic [DSIZE-1:0]  ram_dq_out,
   output logic              ram_dq_oe,
   input  logic [DSIZE-1:0]  ram_dq_in
);

`ifdef ZBT_TURNAROUND_EN
   typedef enum logic [1:0] {IDLE, BURST, TURN} state_t;
`else
   typedef enum logic [1:0] {IDLE, BURST} state_t;
`endif

   state_t state_q, state_d;
   logic [1:0]        beat_cnt_q, beat_cnt_d;
   logic [1:0]        len_q, len_d;
   logic              rw_q, rw_d;
   logic [BWSIZE-1:0] bw_q, bw_d;

   // Pin registers
   logic [ASIZE-1:0]  addr_q, addr_d;
   logic              ce_n_q, ce_n_d;
   logic              rw_n_q, rw_n_d;
   logic              adv_ld_n_q, adv_ld_n_d;
   logic [BWSIZE-1:0] bw_n_q, bw_n_d;

`ifdef ZBT_TURNAROUND_EN
   logic [ASIZE-1:0]  turn_addr_q, turn_addr_d;
   logic              last_rw_q, last_rw_d;
   logic              last_vld_q, last_vld_d;
   logic              go_turn;
`endif

   // Data-phase pipelines
   logic              wd_pop_q;
   logic              wr_s1_q;
   logic              dq_oe_q;
   logic [DSIZE-1:0]  dq_out_q;
   logic [RD_LAT:0]   rd_sh_q, rd_sh_d;
   logic              oe_n_q;
   logic              rd_valid_q;
   logic [DSIZE-1:0]  rd_data_q;

   logic              last_beat;
   logic              accept;
   logic              start_now;
   logic              src_rw;
   logic [ASIZE-1:0]  src_addr;
   logic [BWSIZE-1:0] src_bw;
   logic [1:0]        src_len;

   // Ready is the only combinational output: idle, or final beat now on the pins
   assign last_beat     = (state_q == BURST) && (beat_cnt_q == len_q);
   assign bus.req_ready = (state_q == IDLE) || last_beat;
   assign accept        = bus.req_valid && bus.req_ready;

   // Next-state and next-pin decode; pins default to NOP every cycle
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      len_d      = len_q;
      rw_d       = rw_q;
      bw_d       = bw_q;
      addr_d     = addr_q;
      ce_n_d     = 1'b1;
      rw_n_d     = 1'b1;
      adv_ld_n_d = 1'b0;
      bw_n_d     = '1;
      src_rw     = bus.req_rw_n;
      src_addr   = bus.req_addr;
      src_bw     = bus.req_bw;
      src_len    = bus.req_len;
      start_now  = accept;
`ifdef ZBT_TURNAROUND_EN
      turn_addr_d = turn_addr_q;
      last_rw_d   = last_rw_q;
      last_vld_d  = last_vld_q;
      go_turn     = 1'b0;
      if (state_q == TURN) begin
         // Parked command issues its first beat after the dead cycle
         src_rw    = rw_q;
         src_addr  = turn_addr_q;
         src_bw    = bw_q;
         src_len   = len_q;
         start_now = 1'b1;
      end else if (accept && last_vld_q && (bus.req_rw_n != last_rw_q)) begin
         start_now = 1'b0;
         go_turn   = 1'b1;
      end
`endif

      if ((state_q == BURST) && !last_beat) begin
         // Continuation beat: the SRAM advances its own wrap counter
         beat_cnt_d = beat_cnt_q + 2'd1;
         ce_n_d     = 1'b0;
         rw_n_d     = rw_q;
         adv_ld_n_d = 1'b1;
         bw_n_d     = rw_q ? {BWSIZE{1'b1}} : ~bw_q;
      end else if (start_now) begin
         state_d    = BURST;
         beat_cnt_d = 2'd0;
         len_d      = src_len;
         rw_d       = src_rw;
         bw_d       = src_bw;
         addr_d     = src_addr;
         ce_n_d     = 1'b0;
         rw_n_d     = src_rw;
         adv_ld_n_d = 1'b0;
         bw_n_d     = src_rw ? {BWSIZE{1'b1}} : ~src_bw;
`ifdef ZBT_TURNAROUND_EN
      end else if (go_turn) begin
         state_d     = TURN;
         len_d       = bus.req_len;
         rw_d        = bus.req_rw_n;
         bw_d        = bus.req_bw;
         turn_addr_d = bus.req_addr;
`endif
      end else begin
         state_d = IDLE;
      end

`ifdef ZBT_TURNAROUND_EN
      if (!ce_n_d) begin
         last_rw_d  = rw_n_d;
         last_vld_d = 1'b1;
      end
`endif
   end

   // Read pipeline advances one stage per pins-cycle; stage 0 marks a read beat on the pins
   assign rd_sh_d[0] = ~ce_n_d & rw_n_d;
   generate
      for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_rd_sh
         assign rd_sh_d[gi] = rd_sh_q[gi-1];
      end
   endgenerate

   // FSM, command and pin registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         beat_cnt_q <= 2'd0;
         len_q      <= 2'd0;
         rw_q       <= 1'b1;
         bw_q       <= '0;
         addr_q     <= '0;
         ce_n_q     <= 1'b1;
         rw_n_q     <= 1'b1;
         adv_ld_n_q <= 1'b0;
         bw_n_q     <= '1;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
         rw_q       <= rw_d;
         bw_q       <= bw_d;
         addr_q     <= addr_d;
         ce_n_q     <= ce_n_d;
         rw_n_q     <= rw_n_d;
         adv_ld_n_q <= adv_ld_n_d;
         bw_n_q     <= bw_n_d;
      end
   end

`ifdef ZBT_TURNAROUND_EN
   // Direction of the last issued beat and the parked address during TURN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         turn_addr_q <= '0;
         last_rw_q   <= 1'b1;
         last_vld_q  <= 1'b0;
      end else begin
         turn_addr_q <= turn_addr_d;
         last_rw_q   <= last_rw_d;
         last_vld_q  <= last_vld_d;
      end
   end
`endif

   // Write path: pop at P, sample wr_data at end of P+1, drive pads during P+2
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_pop_q <= 1'b0;
         wr_s1_q  <= 1'b0;
         dq_oe_q  <= 1'b0;
         dq_out_q <= '0;
      end else begin
         wd_pop_q <= ~ce_n_d & ~rw_n_d;
         wr_s1_q  <= wd_pop_q;
         dq_oe_q  <= wr_s1_q;
         if (wr_s1_q) begin
            dq_out_q <= bus.wr_data;
         end
      end
   end

   // Read path: OE low during P+RD_LAT, capture at its end, present during P+RD_LAT+1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_sh_q    <= '0;
         oe_n_q     <= 1'b1;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_sh_q    <= rd_sh_d;
         oe_n_q     <= ~rd_sh_q[RD_LAT-1];
         rd_valid_q <= rd_sh_q[RD_LAT];
         if (rd_sh_q[RD_LAT]) begin
            rd_data_q <= ram_dq_in;
         end
      end
   end

   assign ram_addr     = addr_q;
   assign ram_ce_n     = ce_n_q;
   assign ram_rw_n     = rw_n_q;
   assign ram_adv_ld_n = adv_ld_n_q;
   assign ram_bw_n     = bw_n_q;
   assign ram_oe_n     = oe_n_q;
   assign ram_dq_out   = dq_out_q;
   assign ram_dq_oe    = dq_oe_q;
   assign bus.wd_pop   = wd_pop_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_zbt_sram_ctrl.sv
// Scoreboard bench for zbt_sram_ctrl: stimulus pushes expected pin, write
// and read events with their absolute cycle; a monitor pops them on the
// falling edge as the DUT presents them. A small ZBT model supplies read data.
module tb_zbt_sram_ctrl;
   localparam int ASIZE  = 18;
   localparam int DSIZE  = 32;
   localparam int BWSIZE = 4;
   localparam int RD_LAT = 2;
   localparam int S_PIN = 0, S_WP = 1, S_DQO = 2, S_ROE = 3, S_RV = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ASIZE-1:0]  ram_addr;
   logic              ram_ce_n, ram_rw_n, ram_adv_ld_n, ram_oe_n, ram_dq_oe;
   logic [BWSIZE-1:0] ram_bw_n;
   logic [DSIZE-1:0]  ram_dq_out;
   logic [DSIZE-1:0]  ram_dq_in = '0;

   zbt_sram_ctrl_if #(.ASIZE(ASIZE), .DSIZE(DSIZE), .BWSIZE(BWSIZE)) bus ();

   zbt_sram_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE), .BWSIZE(BWSIZE), .RD_LAT(RD_LAT)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .ram_addr     (ram_addr),
      .ram_ce_n     (ram_ce_n),
      .ram_rw_n     (ram_rw_n),
      .ram_adv_ld_n (ram_adv_ld_n),
      .ram_bw_n     (ram_bw_n),
      .ram_oe_n     (ram_oe_n),
      .ram_dq_out   (ram_dq_out),
      .ram_dq_oe    (ram_dq_oe),
      .ram_dq_in    (ram_dq_in)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          cyc;
      logic [63:0] val;
   } ev_t;

   ev_t         evq [5][$];
   string       sname [5] = '{"pins", "wd_pop", "dq_out", "oe_n", "rd_data"};
   logic [31:0] wdq [$];
   logic [31:0] rsched [int];
   bit          pop_prev = 1'b0;
   logic [ASIZE-1:0] m_base = '0;
   logic [1:0]  m_cnt = '0;
   bit          have_last = 1'b0;
   bit          last_rw = 1'b0;

   function automatic logic [63:0] pinval(input logic rw, input logic adv,
                                          input logic [3:0] bwn, input logic [17:0] a);
      return {40'd0, rw, adv, bwn, a};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic push_ev(input int s, input int c, input logic [63:0] v);
      ev_t e;
      e.cyc = c;
      e.val = v;
      evq[s].push_back(e);
   endtask

   // Pop-and-compare for one output stream; late items count as missing
   task automatic mon_stream(input int s, input bit seen, input logic [63:0] act);
      ev_t e;
      while (evq[s].size() > 0 && evq[s][0].cyc < cyc) begin
         e = evq[s].pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s missing: expected at cycle %0d value %h, not observed", sname[s], e.cyc, e.val);
      end
      if (seen) begin
         n_tests++;
         if (evq[s].size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected: at cycle %0d value %h, none required", sname[s], cyc, act);
         end else begin
            e = evq[s].pop_front();
            if (e.cyc != cyc || e.val !== act) begin
               n_fail++;
               $display("FAIL %s: got cycle %0d value %h, required cycle %0d value %h",
                        sname[s], cyc, act, e.cyc, e.val);
            end
         end
      end
   endtask

   // Monitor: compare every presented output against the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (!ram_ce_n) begin
            mon_stream(S_PIN, 1'b1, pinval(ram_rw_n, ram_adv_ld_n, ram_bw_n, ram_addr));
         end else begin
            mon_stream(S_PIN, 1'b0, 64'd0);
            n_tests++;
            if (ram_adv_ld_n !== 1'b0 || ram_rw_n !== 1'b1 || ram_bw_n !== 4'b1111) begin
               n_fail++;
               $display("FAIL nop_pins cycle %0d: adv_ld_n=%b rw_n=%b bw_n=%b, required 0 1 1111",
                        cyc, ram_adv_ld_n, ram_rw_n, ram_bw_n);
            end
         end
         mon_stream(S_WP,  bus.wd_pop, 64'd0);
         mon_stream(S_DQO, ram_dq_oe, {32'd0, ram_dq_out});
         mon_stream(S_ROE, !ram_oe_n, 64'd0);
         mon_stream(S_RV,  bus.rd_valid, {32'd0, bus.rd_data});
      end
   end

   // ZBT model and write-data source: read data is 0x5A000000 | effective address
   always @(negedge clk) begin
      logic [ASIZE-1:0] eff;
      if (reset) begin
         pop_prev    = 1'b0;
         bus.wr_data = 32'hBAADF00D;
      end else begin
         if (!ram_ce_n) begin
            if (!ram_adv_ld_n) begin
               m_base = ram_addr;
               m_cnt  = 2'd0;
            end else begin
               m_cnt = m_cnt + 2'd1;
            end
            eff = {m_base[ASIZE-1:2], m_base[1:0] + m_cnt};
            if (ram_rw_n) rsched[cyc + RD_LAT] = 32'h5A000000 | 32'(eff);
         end
         ram_dq_in = rsched.exists(cyc) ? rsched[cyc] : 32'hDEADBEEF;
         if (pop_prev && wdq.size() > 0) bus.wr_data = wdq.pop_front();
         else                            bus.wr_data = 32'hBAADF00D;
         pop_prev = bus.wd_pop;
      end
   end

   // Issue one command; pushes expected events up to cycle t+cut_rel
   task automatic send(input bit rw, input logic [17:0] a, input logic [1:0] len,
                       input logic [3:0] bw, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3, input int cut_rel,
                       output int t, output int fb);
      logic [31:0] dv [4];
      int d, p, waitc;
      dv = '{d0, d1, d2, d3};
      bus.req_valid = 1'b1;
      bus.req_rw_n  = rw;
      bus.req_addr  = a;
      bus.req_len   = len;
      bus.req_bw    = bw;
      waitc = 0;
      while (!bus.req_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      t  = cyc;
      fb = cyc + 1;
      if (!bus.req_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: req_ready=0 after 20 cycles, required 1");
         bus.req_valid = 1'b0;
         return;
      end
      d = 0;
`ifdef ZBT_TURNAROUND_EN
      if (have_last && rw != last_rw) d = 1;
`endif
      have_last = 1'b1;
      last_rw   = rw;
      fb = t + 1 + d;
      for (int b = 0; b <= int'(len); b++) begin
         p = fb + b;
         if (p <= t + cut_rel)
            push_ev(S_PIN, p, pinval(rw, (b != 0), rw ? 4'b1111 : ~bw, a));
         if (!rw) begin
            if (p <= t + cut_rel) push_ev(S_WP, p, 64'd0);
            wdq.push_back(dv[b]);
            if (p + 2 <= t + cut_rel) push_ev(S_DQO, p + 2, {32'd0, dv[b]});
         end else begin
            if (p + RD_LAT <= t + cut_rel)     push_ev(S_ROE, p + RD_LAT, 64'd0);
            if (p + RD_LAT + 1 <= t + cut_rel) push_ev(S_RV, p + RD_LAT + 1, {32'd0, dv[b]});
         end
      end
      $display("[TB] cmd %s addr=%05h len=%0d bw=%b accepted cycle %0d first beat %0d",
               rw ? "RD" : "WR", a, len, bw, t, fb);
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_addr"},     64'(ram_addr), 64'd0);
      chk({tag, "_ce_n"},     64'(ram_ce_n), 64'd1);
      chk({tag, "_rw_n"},     64'(ram_rw_n), 64'd1);
      chk({tag, "_adv_ld_n"}, 64'(ram_adv_ld_n), 64'd0);
      chk({tag, "_bw_n"},     64'(ram_bw_n), 64'hF);
      chk({tag, "_oe_n"},     64'(ram_oe_n), 64'd1);
      chk({tag, "_dq_oe"},    64'(ram_dq_oe), 64'd0);
      chk({tag, "_dq_out"},   64'(ram_dq_out), 64'd0);
      chk({tag, "_wd_pop"},   64'(bus.wd_pop), 64'd0);
      chk({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
      chk({tag, "_rd_data"},  64'(bus.rd_data), 64'd0);
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
   endtask

   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int t1, f1, t2, f2;
      bus.req_valid = 1'b0;
      bus.req_rw_n  = 1'b1;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.req_bw    = '0;
      repeat (3) @(negedge clk);
      check_reset("rst0");
      reset = 1'b0;
      @(negedge clk);
      check_reset("idle0");

      // Single write with full byte enables
      send(1'b0, 18'h00010, 2'd0, 4'b1111, 32'hA5A5A5A5, 0, 0, 0, 1000, t1, f1);
      idle(8);

      // 4-beat read from an aligned address, then one that wraps on A[1:0]
      send(1'b1, 18'h00020, 2'd3, 4'b0000, 32'h5A000020, 32'h5A000021, 32'h5A000022, 32'h5A000023,
           1000, t1, f1);
      idle(10);
      send(1'b1, 18'h00032, 2'd3, 4'b0000, 32'h5A000032, 32'h5A000033, 32'h5A000030, 32'h5A000031,
           1000, t1, f1);
      idle(10);

      // Back-to-back writes held valid: second accepted on the first burst's last beat
      send(1'b0, 18'h00040, 2'd1, 4'b1111, 32'h11111111, 32'h22222222, 0, 0, 1000, t1, f1);
      send(1'b0, 18'h00050, 2'd0, 4'b1111, 32'h33333333, 0, 0, 0, 1000, t2, f2);
      chk("gapless_accept", 64'(t2), 64'(f1 + 1));
      idle(8);

      // Read then write: accepted on the read's only beat; any gap comes from TURN
      send(1'b1, 18'h00060, 2'd0, 4'b0000, 32'h5A000060, 0, 0, 0, 1000, t1, f1);
      send(1'b0, 18'h00070, 2'd0, 4'b1111, 32'h44444444, 0, 0, 0, 1000, t2, f2);
      chk("rw_change_accept", 64'(t2), 64'(f1));
      idle(10);

      // Partial byte enables on a 3-beat write
      send(1'b0, 18'h00080, 2'd2, 4'b0101, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 0,
           1000, t1, f1);
      idle(8);

      // Reset during cycle T+3 of a 4-beat read
      send(1'b1, 18'h00090, 2'd3, 4'b0000, 32'h5A000090, 32'h5A000091, 32'h5A000092, 32'h5A000093,
           3, t1, f1);
      bus.req_valid = 1'b0;
      while (cyc < t1 + 3) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset("rst_mid");
      have_last = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(4);

      // Normal operation after reset release
      send(1'b1, 18'h000A4, 2'd1, 4'b0000, 32'h5A0000A4, 32'h5A0000A5, 0, 0, 1000, t1, f1);
      idle(12);

      for (int s = 0; s < 5; s++) chk({"drained_", sname[s]}, 64'(evq[s].size()), 64'd0);
      chk("drained_wdata", 64'(wdq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end
endmodule
